seq_pattern_tx: RTL and testbench

- Serial pattern transmitter that drives the 1-bit x stream consumed by the team's sequence detectors (101 Moore/Mealy, overlapping/non-overlapping).
- Latches a WIDTH-bit pattern on a start pulse and shifts it out MSB first, one bit per clock.
- Repeats the pattern a programmable number of times, with a programmable idle gap between repetitions.
- Serves as the stimulus source for the detectors and as the transmit end of the serial link.

---
 rtl/seq_pattern_tx.sv | 170 +++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter. Latches a WIDTH-bit pattern on
// start and shifts it out MSB first, repeated reps times with gap idle cycles
// between repetitions. All outputs are registered; first bit one clock after start.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    begin a burst (sampled only in IDLE, ignored while busy)
//   abort    synchronous cancel of the burst in progress (wins over start)
//   pattern  bits to send, MSB first
//   reps     number of pattern transmissions (0 behaves as 1)
//   gap      idle cycles between repetitions (0 = back-to-back)
//   x        serial data bit, 0 whenever x_valid is low
//   x_valid  x carries a pattern bit
//   busy     burst in progress (SEND or GAP)
//   done     one-cycle pulse on normal completion
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;     // MSB is the bit currently on x
  logic [WIDTH-1:0] pat_q, pat_d;         // latched copy for reloads
  logic [CNT_W-1:0] rem_q, rem_d;         // repetitions left, including the current one
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d; // gap cycles left, including the current one
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d; // index of the bit currently on x
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      rem_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      rem_q     <= rem_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Outputs are computed for the state being entered and registered, so the
  // registered value always describes the cycle after the edge.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    rem_d     = rem_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    bit_cnt_d = bit_cnt_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_SEND;
          pat_d     = pattern;
          shreg_d   = pattern;
          rem_d     = (reps == '0) ? CNT_W'(1) : reps;
          gap_len_d = gap;
          bit_cnt_d = '0;
          x_d       = pattern[WIDTH-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_q != LAST_BIT) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          x_d       = shreg_q[WIDTH-2];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          // Last bit of this repetition is on x now.
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (gap_len_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_len_q;
            busy_d    = 1'b1;
          end else begin
            // Back-to-back: reload so the next MSB follows with no bubble.
            shreg_d   = pat_q;
            bit_cnt_d = '0;
            x_d       = pat_q[WIDTH-1];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d   = S_SEND;
          gap_cnt_d = '0;
          shreg_d   = pat_q;
          bit_cnt_d = '0;
          x_d       = pat_q[WIDTH-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          busy_d    = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: expected per-cycle {x,x_valid,busy,done}
// tuples are queued when a burst is launched and popped each clock.
// An empty queue means the block must be idle.
module tb_seq_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  int         done_at = -1;
  logic [3:0] exp_q[$];

  seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .reps    (reps),
    .gap     (gap),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cyc=%0d got {x,v,b,d}=%b want %b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s got %0d want %0d", tag, obs, expv);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, compare to scoreboard.
  task automatic tick(input string tag);
    logic [3:0] o;
    logic [3:0] e;
    @(posedge clk);
    #1;
    cyc++;
    o = {x, x_valid, busy, done};
    if (busy) busy_cnt++;
    if (done && done_at < 0) done_at = cyc;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
    check(tag, o, e);
  endtask

  task automatic push_burst(input logic [WIDTH-1:0] p, input int r, input int g);
    int n;
    n = (r == 0) ? 1 : r;
    for (int rep = 0; rep < n; rep++) begin
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
      if (rep < n - 1)
        for (int k = 0; k < g; k++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endtask

  // Drive start for one edge; the tick that follows checks cycle 1.
  task automatic launch(input string tag, input logic [WIDTH-1:0] p, input int r, input int g);
    pattern = p;
    reps    = CNT_W'(r);
    gap     = GAP_W'(g);
    start   = 1'b1;
    push_burst(p, r, g);
    cyc      = 0;
    busy_cnt = 0;
    done_at  = -1;
    tick(tag);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) tick(tag);
    tick({tag, "_idle"});
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    reps    = '0;
    gap     = '0;

    // Reset state
    #1;
    check("reset", {x, x_valid, busy, done}, 4'b0000);
    tick("reset_hold");
    tick("reset_hold");
    #2 reset = 1'b1;
    tick("post_reset_idle");

    // Single burst
    launch("single", 8'b1010_0000, 1, 0);
    drain("single");
    check_int("single_busy_cycles", busy_cnt, 8);
    check_int("single_done_cycle", done_at, 9);

    // Repeat with gap
    launch("gap", 8'hA5, 3, 2);
    drain("gap");
    check_int("gap_busy_cycles", busy_cnt, 28);
    check_int("gap_done_cycle", done_at, 29);

    // Back-to-back; start and input changes mid-burst are ignored
    launch("b2b", 8'b1011_0101, 2, 0);
    tick("b2b");
    tick("b2b");
    tick("b2b");
    start   = 1'b1;
    pattern = 8'h00;
    reps    = 4'hF;
    gap     = 3'd7;
    tick("b2b_midstart");
    start = 1'b0;
    drain("b2b");
    check_int("b2b_busy_cycles", busy_cnt, 16);
    check_int("b2b_done_cycle", done_at, 17);

    // Abort at cycle 10, restart with start in cycle 12
    launch("abort", 8'hC3, 4, 0);
    for (int i = 0; i < 9; i++) tick("abort_run");
    abort = 1'b1;
    exp_q.delete();
    tick("abort_cut");
    abort = 1'b0;
    tick("abort_idle");
    check_int("abort_no_done", done_at, -1);
    launch("abort_restart", 8'h5A, 1, 0);
    drain("abort_restart");

    // Asynchronous reset mid-burst, then reps=0
    launch("rst_mid", 8'hA5, 3, 1);
    tick("rst_mid");
    tick("rst_mid");
    tick("rst_mid");
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    check("rst_async", {x, x_valid, busy, done}, 4'b0000);
    tick("rst_held");
    tick("rst_held");
    check_int("rst_no_done", done_at, -1);
    #2 reset = 1'b1;
    tick("rst_release");
    launch("reps0", 8'hFF, 0, 0);
    drain("reps0");
    check_int("reps0_busy_cycles", busy_cnt, 8);

    // Start in the done cycle
    launch("on_done_a", 8'h96, 1, 0);
    for (int i = 0; i < 8; i++) tick("on_done_a");
    check_int("on_done_queue_empty", exp_q.size(), 0);
    launch("on_done_b", 8'h3C, 2, 1);
    drain("on_done_b");
    check_int("on_done_b_busy", busy_cnt, 17);

    // Abort and start together in IDLE: no burst
    start = 1'b1;
    abort = 1'b1;
    tick("collide");
    start = 1'b0;
    abort = 1'b0;
    tick("collide_idle");
    tick("collide_idle");
    tick("collide_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
